shift_acc_ctrl: RTL and testbench
=================================

SHIFT_ACC_CTRL -- requirements
Module: shift_acc_ctrl

Interface
REQ-001 Parameter IN_WIDTH, default 12: activation width, signed two's complement.
REQ-002 Parameter OUT_WIDTH, default 19: shifter output width, IN_WIDTH+7.
REQ-003 Parameter ACC_WIDTH, default 20: accumulator/result width, OUT_WIDTH+1.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  act/wgt pair offered.
REQ-007 in_ready  output  1  block accepts a pair this cycle.
REQ-008 act  input  IN_WIDTH  signed activation.
REQ-009 wgt  input  8  signed two's-complement weight; bit 7 has weight -128.
REQ-010 out_valid  output  1  result is valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 result  output  ACC_WIDTH  signed product act*wgt.
REQ-013 shift_sel  output  3  shift amount currently applied to the internal shifter (observability).
REQ-014 busy  output  1  high in RUN state.

Function
REQ-015 Block SHALL instantiate one shifter (IN_WIDTH, OUT_WIDTH), fed by the latched act and shift_sel, output sign-extended to ACC_WIDTH.
REQ-016 FSM SHALL have states IDLE, RUN, DONE; in_ready = (state==IDLE); out_valid = (state==DONE); busy = (state==RUN).
REQ-017 IDLE, in_valid=1: latch act into act_q, wgt into pending mask, clear acc; go to RUN if wgt!=0, else DONE.
REQ-018 RUN: each cycle select lowest set bit k of pending mask, drive shift_sel=k, clear bit k.
REQ-019 RUN, k<7: acc <= acc + sext(act_q<<k); k==7: acc <= acc - sext(act_q<<7).
REQ-020 RUN SHALL go to DONE in the cycle that clears the last set bit; RUN lasts exactly popcount(wgt) cycles.
REQ-021 shift_sel SHALL read 0 outside RUN.
REQ-022 DONE: result = acc, held stable while out_ready=0; out_valid=1 and out_ready=1 -> IDLE next edge.
REQ-023 No new pair SHALL be accepted in RUN or DONE; in_valid there is ignored, and act/wgt changes SHALL NOT affect the computation in flight.
REQ-024 Latency: accept edge to out_valid = popcount(wgt)+1 edges (1 for wgt=0); throughput is one pair per latency+1 cycles minimum.
REQ-025 Arithmetic SHALL be exact: result == act*wgt for all inputs, no saturation; ACC_WIDTH holds (-2048)*(-128)=262144.
REQ-026 result SHALL be registered; no combinational path from in_valid/out_ready to result.

Reset
REQ-027 rst_n=0 SHALL immediately force state=IDLE, acc=0, act_q=0, pending mask=0; outputs in_ready=1 (after reset release), out_valid=0, busy=0, shift_sel=0, result=0.
REQ-028 Reset asserted mid-RUN or mid-DONE SHALL discard the operation; no out_valid follows release.
REQ-029 First acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-030 act=3, wgt=8'h05, out_ready=1 -> busy 2 cycles, shift_sel 0 then 2, out_valid on edge 3 after accept, result=15.
REQ-031 act=12'b111011110011 (-269), wgt=8'hFF (-1) -> shift_sel 0..7 over 8 cycles, result=269.
REQ-032 act=-2048, wgt=8'h80 -> 1 RUN cycle, shift_sel=7, result=262144; act=2047, wgt=8'h7F -> result=259969.
REQ-033 wgt=0, act=any -> no RUN, out_valid 1 edge after accept, result=0; in_valid held high during DONE not accepted.
REQ-034 Backpressure: out_ready=0 for 5 cycles in DONE -> result/out_valid stable, in_ready=0; out_ready=1 -> IDLE next edge.
REQ-035 rst_n pulsed low during RUN of act=5, wgt=8'h0F -> all outputs at reset values, no out_valid; next pair act=1, wgt=1 -> result=1.

Source files
------------

// File: rtl/shift_acc_ctrl.sv
// Shift-and-add signed multiplier controller: multiplies a latched activation
// by an 8-bit two's-complement weight, one set weight bit per RUN cycle.

module shift_acc_shifter #(
  parameter int IN_WIDTH  = 12,
  parameter int OUT_WIDTH = 19
) (
  input  logic signed [IN_WIDTH-1:0]  din,
  input  logic        [2:0]           shamt,
  output logic signed [OUT_WIDTH-1:0] dout
);

  logic signed [OUT_WIDTH-1:0] din_ext;

  always_comb begin
    din_ext = {{(OUT_WIDTH-IN_WIDTH){din[IN_WIDTH-1]}}, din};
    dout    = din_ext << shamt;
  end

endmodule

module shift_acc_ctrl #(
  parameter int IN_WIDTH  = 12,
  parameter int OUT_WIDTH = 19,
  parameter int ACC_WIDTH = 20
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [IN_WIDTH-1:0]  act,
  input  logic        [7:0]           wgt,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [ACC_WIDTH-1:0] result,
  output logic        [2:0]           shift_sel,
  output logic                        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic signed [IN_WIDTH-1:0]  act_q,   act_d;
  logic        [7:0]           mask_q,  mask_d;
  logic signed [ACC_WIDTH-1:0] acc_q,   acc_d;

  logic        [2:0]           low_bit;
  logic                        low_found;
  logic signed [OUT_WIDTH-1:0] shift_out;
  logic signed [ACC_WIDTH-1:0] shift_ext;

  // Lowest pending bit; kept apart from the datapath block so the shifter
  // input never depends on the accumulator update.
  always_comb begin
    low_bit   = 3'd0;
    low_found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!low_found && mask_q[i]) begin
        low_bit   = 3'(i);
        low_found = 1'b1;
      end
    end
    shift_sel = (state_q == RUN) ? low_bit : 3'd0;
  end

  shift_acc_shifter #(
    .IN_WIDTH (IN_WIDTH),
    .OUT_WIDTH(OUT_WIDTH)
  ) u_shifter (
    .din  (act_q),
    .shamt(shift_sel),
    .dout (shift_out)
  );

  assign shift_ext = {{(ACC_WIDTH-OUT_WIDTH){shift_out[OUT_WIDTH-1]}}, shift_out};

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    mask_d  = mask_q;
    acc_d   = acc_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          act_d   = act;
          mask_d  = wgt;
          acc_d   = '0;
          state_d = (wgt != 8'd0) ? RUN : DONE;
        end
      end
      RUN: begin
        mask_d = mask_q & (mask_q - 8'd1);
        // Bit 7 of a two's-complement weight carries -128.
        if (shift_sel == 3'd7) acc_d = acc_q - shift_ext;
        else                   acc_d = acc_q + shift_ext;
        if (mask_d == 8'd0) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      act_q   <= '0;
      mask_q  <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      mask_q  <= mask_d;
      acc_q   <= acc_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN);
  assign result    = acc_q;

endmodule

// File: tb/tb_shift_acc_ctrl.sv
// Self-checking bench for shift_acc_ctrl: transaction-level model compared
// every cycle, plus directed vectors with hand-computed results and latencies.

module tb_shift_acc_ctrl;

  localparam int IW = 12;
  localparam int OW = 19;
  localparam int AW = 20;

  logic                 clk       = 1'b0;
  logic                 rst_n     = 1'b0;
  logic                 in_valid  = 1'b0;
  logic                 out_ready = 1'b1;
  logic signed [IW-1:0] act       = '0;
  logic        [7:0]    wgt       = '0;
  logic                 in_ready, out_valid, busy;
  logic signed [AW-1:0] result;
  logic        [2:0]    shift_sel;

  int n_checks = 0;
  int n_errors = 0;
  int lat      = 0;

  shift_acc_ctrl #(
    .IN_WIDTH (IW),
    .OUT_WIDTH(OW),
    .ACC_WIDTH(AW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .act      (act),
    .wgt      (wgt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .shift_sel(shift_sel),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic signed [63:0] actual,
                       input logic signed [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Transaction model: a queue of the weight's set-bit positions (one per RUN
  // cycle, lowest first), the exact product, and a pending-result flag.
  bit      m_idle = 1'b1;
  bit      m_done = 1'b0;
  int      m_q[$];
  longint  m_prod = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_idle = 1'b1;
      m_done = 1'b0;
      m_q.delete();
      m_prod = 0;
    end else if (m_idle) begin
      if (in_valid) begin
        m_q.delete();
        for (int i = 0; i < 8; i++) if (wgt[i]) m_q.push_back(i);
        m_prod = longint'(act) * longint'($signed(wgt));
        m_idle = 1'b0;
        m_done = (m_q.size() == 0);
      end
    end else if (m_q.size() > 0) begin
      void'(m_q.pop_front());
      if (m_q.size() == 0) m_done = 1'b1;
    end else if (m_done && out_ready) begin
      m_done = 1'b0;
      m_idle = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("model_in_ready",  in_ready,  m_idle);
      check("model_busy",      busy,      m_q.size() > 0);
      check("model_shift_sel", shift_sel, (m_q.size() > 0) ? m_q[0] : 0);
      check("model_out_valid", out_valid, m_done);
      if (m_done) check("model_result", result, m_prod);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    lat++;
  endtask

  // Offer one pair; returns #1 after the accepting edge with lat = 1.
  task automatic send(input int a, input logic [7:0] w, input bit hold);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: got in_ready=%0b, expected 1", in_ready);
    end
    in_valid = 1'b1;
    act      = IW'(a);
    wgt      = w;
    @(posedge clk);
    #1;
    lat = 1;
    if (!hold) in_valid = 1'b0;
    act = IW'($urandom);
    wgt = 8'($urandom);
  endtask

  task automatic wait_result(input string name, input int exp_lat, input int exp_res);
    while (!out_valid && lat < 40) step();
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_result"}, result, exp_res);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_out_valid"}, out_valid, 0);
    check({name, "_busy"},      busy,      0);
    check({name, "_shift_sel"}, shift_sel, 0);
    check({name, "_result"},    result,    0);
    check({name, "_in_ready"},  in_ready,  1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // act=3, wgt=5: first edge after release accepts; shift_sel 0 then 2.
    send(3, 8'h05, 1'b0);
    check("t1_busy", busy, 1);
    check("t1_sel_a", shift_sel, 0);
    step();
    check("t1_sel_b", shift_sel, 2);
    wait_result("t1", 3, 15);
    step();

    // act=-269, wgt=-1: every bit set, subtract on bit 7.
    send(-269, 8'hFF, 1'b0);
    for (int i = 0; i < 8; i++) begin
      check("t2_sel", shift_sel, i);
      if (i < 7) step();
    end
    wait_result("t2", 9, 269);
    step();

    // Extremes of the result range.
    send(-2048, 8'h80, 1'b0);
    check("t3_sel", shift_sel, 7);
    wait_result("t3", 2, 262144);
    step();
    send(2047, 8'h7F, 1'b0);
    wait_result("t4", 8, 259969);
    step();

    // wgt=0 with in_valid held through DONE: not re-accepted there.
    send(-77, 8'h00, 1'b1);
    wait_result("t5", 1, 0);
    check("t5_ready_in_done", in_ready, 0);
    step();
    check("t5_ready_after", in_ready, 1);
    check("t5_valid_after", out_valid, 0);
    in_valid = 1'b0;

    // Backpressure: result held for 5 cycles.
    out_ready = 1'b0;
    send(-100, 8'h3C, 1'b0);
    wait_result("t6", 5, -6000);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t6_hold_valid", out_valid, 1);
      check("t6_hold_result", result, -6000);
      check("t6_hold_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    check("t6_release_valid", out_valid, 0);
    check("t6_release_ready", in_ready, 1);

    // Mixed signs.
    send(-5, 8'h81, 1'b0);
    wait_result("t7a", 3, 635);
    step();
    send(1000, 8'hA6, 1'b0);
    wait_result("t7b", 5, -90000);
    step();

    // Reset in the middle of RUN discards the operation.
    send(5, 8'h0F, 1'b0);
    step();
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("t8_rst");
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("t8_no_valid", out_valid, 0);
    end
    send(1, 8'h01, 1'b0);
    wait_result("t8", 2, 1);
    step();
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
